// File: rtl/fifo_rr_push_arbiter_if.sv
// Push-side bundle between the producers, the round-robin push arbiter and the shared fifo.
// slave is the arbiter's view; master is the view of the producers plus fifo environment.
interface fifo_rr_push_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INDEX_BITS = $clog2(DEPTH + 1),
  parameter int unsigned REQ_BITS   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          flush_req_i;
  logic                          flush_done_o;
  logic                          grant_valid_o;
  logic [REQ_BITS-1:0]           grant_id_o;
  logic                          fifo_full_i;
  logic [INDEX_BITS-1:0]         fifo_usage_i;
  logic                          fifo_push_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          fifo_flush_o;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  flush_req_i,
    input  fifo_full_i,
    input  fifo_usage_i,
    output req_ready_o,
    output flush_done_o,
    output grant_valid_o,
    output grant_id_o,
    output fifo_push_o,
    output fifo_data_o,
    output fifo_flush_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output flush_req_i,
    output fifo_full_i,
    output fifo_usage_i,
    input  req_ready_o,
    input  flush_done_o,
    input  grant_valid_o,
    input  grant_id_o,
    input  fifo_push_o,
    input  fifo_data_o,
    input  fifo_flush_o
  );
endinterface

// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin push arbiter with bounded bursts and flush sequencing for one shared fifo.
// Optional per-requester saturating grant counters when FIFO_ARB_STATS_EN is defined.
module fifo_rr_push_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned INDEX_BITS = $clog2(DEPTH + 1),
  parameter int unsigned REQ_BITS   = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  fifo_rr_push_arbiter_if.slave     bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants_o
`endif
);

  localparam int unsigned CNT_BITS = $clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] BurstLast = CNT_BITS'(MAX_BURST - 1);
  localparam logic [REQ_BITS:0]   NumReqW   = (REQ_BITS + 1)'(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StBurst, StFlush} state_e;

  state_e              r_state, w_state_d;
  logic [REQ_BITS-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [REQ_BITS-1:0] r_owner, w_owner_d;
  logic [CNT_BITS-1:0] r_burst_cnt, w_burst_cnt_d;

  logic                  w_found;
  logic [REQ_BITS-1:0]   w_sel;
  logic [REQ_BITS:0]     w_scan;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_xfer;
  logic [REQ_BITS-1:0]   w_xfer_id;
  logic [DATA_WIDTH-1:0] w_data;
  logic [INDEX_BITS-1:0] w_unused_usage;

  assign w_unused_usage = bus.fifo_usage_i;

  function automatic logic [REQ_BITS-1:0] next_idx(input logic [REQ_BITS-1:0] idx);
    if (idx == REQ_BITS'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + REQ_BITS'(1);
  endfunction

  // First valid requester scanning upward from r_rr_ptr; wraps explicitly so any NUM_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (REQ_BITS + 1)'(k);
      if (w_scan >= NumReqW) begin
        w_scan = w_scan - NumReqW;
      end
      if (!w_found && bus.req_valid_i[w_scan[REQ_BITS-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_scan[REQ_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_owner     <= w_owner_d;
      r_burst_cnt <= w_burst_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_owner_d     = r_owner;
    w_burst_cnt_d = r_burst_cnt;
    if (r_state != StFlush && bus.flush_req_i) begin
      w_state_d     = StFlush;
      w_owner_d     = '0;
      w_burst_cnt_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_xfer) begin
            w_owner_d     = w_sel;
            w_burst_cnt_d = CNT_BITS'(1);
            if (MAX_BURST == 1) begin
              w_rr_ptr_d = next_idx(w_sel);
            end else begin
              w_state_d = StBurst;
            end
          end
        end
        StBurst: begin
          // Owner dropping valid ends the burst; a full fifo only stalls it.
          if (!bus.req_valid_i[r_owner]) begin
            w_rr_ptr_d    = next_idx(r_owner);
            w_burst_cnt_d = '0;
            w_state_d     = StIdle;
          end else if (w_xfer) begin
            if (r_burst_cnt == BurstLast) begin
              w_rr_ptr_d    = next_idx(r_owner);
              w_burst_cnt_d = '0;
              w_state_d     = StIdle;
            end else begin
              w_burst_cnt_d = r_burst_cnt + CNT_BITS'(1);
            end
          end
        end
        StFlush: w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Ready is only raised together with the matching valid, so ready alone marks a transfer.
  always_comb begin
    w_ready   = '0;
    w_xfer_id = r_owner;
    unique case (r_state)
      StIdle: begin
        w_xfer_id = w_sel;
        if (!bus.flush_req_i && !bus.fifo_full_i && w_found) begin
          w_ready[w_sel] = 1'b1;
        end
      end
      StBurst: begin
        if (!bus.flush_req_i && !bus.fifo_full_i && bus.req_valid_i[r_owner]) begin
          w_ready[r_owner] = 1'b1;
        end
      end
      default: w_ready = '0;
    endcase
    if (rst_i) begin
      w_ready = '0;
    end
  end

  assign w_xfer = |w_ready;

  always_comb begin
    w_data = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (w_xfer && w_xfer_id == REQ_BITS'(r)) begin
        w_data = bus.req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.req_ready_o   = w_ready;
  assign bus.fifo_push_o   = w_xfer;
  assign bus.grant_valid_o = w_xfer;
  assign bus.grant_id_o    = w_xfer ? w_xfer_id : '0;
  assign bus.fifo_data_o   = w_data;
  assign bus.fifo_flush_o  = (r_state == StFlush) && !rst_i;
  assign bus.flush_done_o  = (r_state == StFlush) && !rst_i;

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [15:0] r_stat;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_stat <= '0;
      end else if (w_xfer && w_xfer_id == REQ_BITS'(g) && r_stat != 16'hFFFF) begin
        r_stat <= r_stat + 16'd1;
      end
    end
    assign stat_grants_o[g*16 +: 16] = r_stat;
  end
`endif

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Directed bench for fifo_rr_push_arbiter: a queue-free behavioural model checked every cycle
// plus hand-computed grant sequences for each scenario.
module tb_fifo_rr_push_arbiter;
  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MB    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rr_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_if ();

`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] stat;
`endif

  fifo_rr_push_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus_if)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_grants_o(stat)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = burst, 2 = flush. Updated once per cycle at the sample point.
  int m_mode = 0, m_ptr = 0, m_owner = 0, m_beats = 0, sr = 0;
  logic           e_gv, e_fl;
  int             e_id;
  logic [NR-1:0]  e_ready;
  logic [DW-1:0]  e_data;
  int             m_cnt[NR];

  initial begin
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    forever begin
      @(negedge clk);
      e_gv = 1'b0; e_fl = 1'b0; e_id = 0; e_ready = '0; e_data = '0;
      if (rst) begin
        m_mode = 0; m_ptr = 0; m_owner = 0; m_beats = 0;
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      end else if (m_mode == 2) begin
        e_fl = 1'b1;
        m_mode = 0;
      end else if (bus_if.flush_req_i) begin
        m_mode = 2; m_owner = 0; m_beats = 0;
      end else if (m_mode == 0) begin
        if (!bus_if.fifo_full_i) begin
          for (int k = 0; k < NR; k++) begin
            sr = (m_ptr + k) % NR;
            if (!e_gv && bus_if.req_valid_i[sr]) begin
              e_gv = 1'b1;
              e_id = sr;
            end
          end
        end
        if (e_gv) begin
          m_owner = e_id; m_beats = 1;
          if (MB == 1) m_ptr = (e_id + 1) % NR;
          else m_mode = 1;
        end
      end else begin
        if (!bus_if.req_valid_i[m_owner]) begin
          m_ptr = (m_owner + 1) % NR; m_mode = 0;
        end else if (!bus_if.fifo_full_i) begin
          e_gv = 1'b1; e_id = m_owner; m_beats++;
          if (m_beats == MB) begin
            m_ptr = (m_owner + 1) % NR; m_beats = 0; m_mode = 0;
          end
        end
      end
      if (e_gv) begin
        e_ready[e_id] = 1'b1;
        e_data = bus_if.req_data_i[e_id*DW +: DW];
        if (m_cnt[e_id] < 65535) m_cnt[e_id]++;
      end
      check("model_ready", 64'(bus_if.req_ready_o), 64'(e_ready));
      check("model_push", 64'(bus_if.fifo_push_o), 64'(e_gv));
      check("model_grant_valid", 64'(bus_if.grant_valid_o), 64'(e_gv));
      check("model_grant_id", 64'(bus_if.grant_id_o), 64'(e_id));
      check("model_data", 64'(bus_if.fifo_data_o), 64'(e_data));
      check("model_flush", 64'(bus_if.fifo_flush_o), 64'(e_fl));
      check("model_flush_done", 64'(bus_if.flush_done_o), 64'(e_fl));
`ifdef FIFO_ARB_STATS_EN
      // Counters are registered: compare against counts from completed cycles only.
      for (int r = 0; r < NR; r++) begin
        if (!rst) check("model_stat", 64'(stat[r*16 +: 16]),
                        64'(m_cnt[r] - ((e_gv && e_id == r && m_cnt[r] < 65535) ? 1 : 0)));
      end
`endif
    end
  end

  // One cycle of directed stimulus plus its hand-computed expectation (exp_id < 0: no grant).
  task automatic cyc(input logic r, input logic [NR-1:0] v, input logic fl, input logic full,
                     input int exp_id, input logic exp_fl, input string name);
    @(posedge clk);
    #1;
    rst = r;
    bus_if.req_valid_i = v;
    bus_if.flush_req_i = fl;
    bus_if.fifo_full_i = full;
    for (int k = 0; k < NR; k++) bus_if.req_data_i[k*DW +: DW] = {8'hA0 + 8'(k), 24'(cyc_no)};
    cyc_no++;
    @(negedge clk);
    check({name, "_gv"}, 64'(bus_if.grant_valid_o), 64'(exp_id >= 0));
    if (exp_id >= 0) begin
      check({name, "_id"}, 64'(bus_if.grant_id_o), 64'(exp_id));
      check({name, "_data"}, 64'(bus_if.fifo_data_o), 64'({8'hA0 + 8'(exp_id), 24'(cyc_no - 1)}));
    end
    check({name, "_flush"}, 64'(bus_if.fifo_flush_o), 64'(exp_fl));
  endtask

  initial begin
    bus_if.req_valid_i  = '0;
    bus_if.req_data_i   = '0;
    bus_if.flush_req_i  = 1'b0;
    bus_if.fifo_full_i  = 1'b0;
    bus_if.fifo_usage_i = 4'd3;

    // Outputs stay low while reset is held, even with every requester valid.
    cyc(1, 4'b1111, 0, 0, -1, 0, "reset0");
    cyc(1, 4'b1111, 1, 0, -1, 0, "reset1");

    // All valid: bursts of four, wrapping 3 -> 0.
    for (int i = 0; i < 17; i++) cyc(0, 4'b1111, 0, 0, (i / 4) % 4, 0, "rr_all");
    cyc(0, 4'b0000, 0, 0, -1, 0, "rr_drop");

    // Short burst by 1, one idle cycle, then 2.
    cyc(0, 4'b0110, 0, 0, 1, 0, "short_a");
    cyc(0, 4'b0110, 0, 0, 1, 0, "short_b");
    cyc(0, 4'b0100, 0, 0, -1, 0, "short_gap");
    cyc(0, 4'b0100, 0, 0, 2, 0, "short_next");
    cyc(0, 4'b0000, 0, 0, -1, 0, "short_end");

    // Full stalls requester 0 mid-burst; burst resumes, then requester 1.
    cyc(0, 4'b0011, 0, 0, 0, 0, "full_a");
    cyc(0, 4'b0011, 0, 0, 0, 0, "full_b");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0011, 0, 1, -1, 0, "full_stall");
    cyc(0, 4'b0011, 0, 0, 0, 0, "full_c");
    cyc(0, 4'b0011, 0, 0, 0, 0, "full_d");
    cyc(0, 4'b0011, 0, 0, 1, 0, "full_next");
    cyc(0, 4'b0000, 0, 0, -1, 0, "full_end");

    // Flush during requester 3's burst; rr pointer (2) survives the flush.
    cyc(0, 4'b1000, 0, 0, 3, 0, "fl_grant");
    cyc(0, 4'b1000, 1, 0, -1, 0, "fl_req");
    cyc(0, 4'b1000, 0, 0, -1, 1, "fl_pulse");
    cyc(0, 4'b1100, 0, 0, 2, 0, "fl_resume");
    // Held flush request: FLUSH, consumed IDLE, FLUSH again.
    cyc(0, 4'b1100, 1, 0, -1, 0, "flh_req");
    cyc(0, 4'b1100, 1, 0, -1, 1, "flh_pulse1");
    cyc(0, 4'b1100, 1, 0, -1, 0, "flh_idle");
    cyc(0, 4'b1100, 0, 0, -1, 1, "flh_pulse2");
    cyc(0, 4'b1111, 0, 1, -1, 0, "idle_full");

    // Reset in the middle of requester 2's burst clears the rr pointer.
    cyc(0, 4'b0100, 0, 0, 2, 0, "rst_a");
    cyc(0, 4'b0100, 0, 0, 2, 0, "rst_b");
    cyc(1, 4'b0101, 0, 0, -1, 0, "rst_hold0");
    cyc(1, 4'b0101, 0, 0, -1, 0, "rst_hold1");
    for (int i = 0; i < 4; i++) cyc(0, 4'b0101, 0, 0, 0, 0, "rst_after");
    cyc(0, 4'b0101, 0, 0, 2, 0, "rst_next");
    cyc(0, 4'b0000, 0, 0, -1, 0, "rst_end");

`ifdef FIFO_ARB_STATS_EN
    cyc(1, 4'b0000, 0, 0, -1, 0, "stat_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.req_valid_i = 4'b0001;
    repeat (70000) @(posedge clk);
    #1;
    bus_if.req_valid_i = 4'b0000;
    @(negedge clk);
    check("stat_sat_r0", 64'(stat[15:0]), 64'hFFFF);
    check("stat_r1", 64'(stat[31:16]), 64'h0);
    check("stat_r2", 64'(stat[47:32]), 64'h0);
    check("stat_r3", 64'(stat[63:48]), 64'h0);
`endif

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
